// File: rtl/pairhmm_pkg.sv
// -----------------------------------------------------------------------------
// pairhmm_pkg
// Shared definitions for the PairHMM result path.
//   PHMM_LANE_W   : width of one likelihood result (IEEE-754 single)
//   PHMM_LANES    : results packed into one result-FIFO word
//   PHMM_DATA_W   : result-FIFO word width
//   LANE0_AT_LSB  : lane ordering inside a FIFO word (1 = lane 0 is bits [31:0])
//   state_e       : result-unpacker control states
// -----------------------------------------------------------------------------
package pairhmm_pkg;

    localparam int PHMM_LANE_W = 32;
    localparam int PHMM_LANES  = 4;
    localparam int PHMM_DATA_W = PHMM_LANES * PHMM_LANE_W;

    // The diagonal engine writes pair k of a word into the k-th least
    // significant lane, so lane 0 sits at the bottom of the word.
    localparam bit LANE0_AT_LSB = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/pairhmm_result_unpack.sv
// -----------------------------------------------------------------------------
// pairhmm_result_unpack
// Drains the PairHMM diagonal result FIFO (LANES results per word) and
// serialises the results onto a valid/ready stream tagged with a 0-based
// pair index. A job of num_pairs results is launched by start; padding lanes
// of the final word are dropped and done pulses once at the end.
//
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   start, num_pairs         job launch (accepted in IDLE only) and length
//   result_fifo_empty/rd     FIFO status / read strobe (one word per cycle)
//   result_fifo_rdat         FIFO read data, valid the cycle after rd
//   res_valid/ready          result stream handshake
//   res_data, res_id         result value and its pair index
//   res_last                 final result of the job
//   busy, done               job in progress / single-cycle completion pulse
// -----------------------------------------------------------------------------
module pairhmm_result_unpack #(
    parameter int DATA_W = pairhmm_pkg::PHMM_DATA_W,
    parameter int LANE_W = pairhmm_pkg::PHMM_LANE_W,
    parameter int LANES  = pairhmm_pkg::PHMM_LANES,
    parameter int ID_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [ID_W-1:0]   num_pairs,
    input  logic              result_fifo_empty,
    output logic              result_fifo_rd,
    input  logic [DATA_W-1:0] result_fifo_rdat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LANE_W-1:0] res_data,
    output logic [ID_W-1:0]   res_id,
    output logic              res_last,
    output logic              busy,
    output logic              done
);

    import pairhmm_pkg::*;

    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     word_q,  word_d;
    logic [LANE_IDX_W-1:0] lane_q,  lane_d;
    logic [ID_W-1:0]       rem_q,   rem_d;
    logic [ID_W-1:0]       id_q,    id_d;

    // Lane multiplexer: picks one result out of the captured word.
    function automatic logic [LANE_W-1:0] lane_sel(
        input logic [DATA_W-1:0]     word,
        input logic [LANE_IDX_W-1:0] lane
    );
        logic [LANE_IDX_W-1:0] slot;
        slot = LANE0_AT_LSB ? lane : (LAST_LANE - lane);
        return word[int'(slot) * LANE_W +: LANE_W];
    endfunction

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        lane_d         = lane_q;
        rem_d          = rem_q;
        id_d           = id_q;
        result_fifo_rd = 1'b0;
        res_valid      = 1'b0;
        res_data       = '0;
        res_id         = '0;
        res_last       = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_pairs == '0) begin
                        rem_d   = '0;
                        state_d = FINISH;
                    end else begin
                        rem_d   = num_pairs;
                        id_d    = '0;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            FETCH: begin
                // Gated by reset so a word is never popped in the reset cycle.
                result_fifo_rd = !result_fifo_empty && !sys_rst;
                if (!result_fifo_empty) begin
                    state_d = LOAD;
                end else begin
                    state_d = FETCH;
                end
            end

            LOAD: begin
                word_d  = result_fifo_rdat;
                lane_d  = '0;
                state_d = EMIT;
            end

            EMIT: begin
                // Outputs depend only on registers, so they hold during a stall.
                res_valid = 1'b1;
                res_data  = lane_sel(word_q, lane_q);
                res_id    = id_q;
                res_last  = (rem_q == ID_W'(1));
                if (res_ready) begin
                    id_d  = id_q + ID_W'(1);
                    rem_d = rem_q - ID_W'(1);
                    if (rem_q == ID_W'(1)) begin
                        // Remaining lanes of this word are padding.
                        state_d = FINISH;
                    end else if (lane_q == LAST_LANE) begin
                        state_d = FETCH;
                    end else begin
                        lane_d  = lane_q + LANE_IDX_W'(1);
                    end
                end else begin
                    state_d = EMIT;
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_pairhmm_result_unpack.sv
// -----------------------------------------------------------------------------
// tb_pairhmm_result_unpack
// Self-checking bench: a behavioural FIFO feeds random (or fixed) words, and
// the expected result stream of each job is derived from the words by plain
// lane arithmetic. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pairhmm_result_unpack;

    localparam int DATA_W = 128;
    localparam int LANE_W = 32;
    localparam int LANES  = 4;
    localparam int ID_W   = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              start;
    logic [ID_W-1:0]   num_pairs;
    logic              result_fifo_empty;
    logic              result_fifo_rd;
    logic [DATA_W-1:0] result_fifo_rdat;
    logic              res_valid;
    logic              res_ready;
    logic [LANE_W-1:0] res_data;
    logic [ID_W-1:0]   res_id;
    logic              res_last;
    logic              busy;
    logic              done;

    pairhmm_result_unpack #(
        .DATA_W(DATA_W), .LANE_W(LANE_W), .LANES(LANES), .ID_W(ID_W)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .start            (start),
        .num_pairs        (num_pairs),
        .result_fifo_empty(result_fifo_empty),
        .result_fifo_rd   (result_fifo_rd),
        .result_fifo_rdat (result_fifo_rdat),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_id           (res_id),
        .res_last         (res_last),
        .busy             (busy),
        .done             (done)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural result FIFO: data appears on rdat the cycle after rd.
    logic [DATA_W-1:0] fifo_mem [0:255];
    int  push_cnt = 0;
    int  pop_cnt  = 0;
    logic force_empty;
    assign result_fifo_empty = force_empty || (push_cnt == pop_cnt);

    // FIFO read side; the FIFO is flushed by the shared reset.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            pop_cnt <= push_cnt;
        end else if (result_fifo_rd && (push_cnt != pop_cnt)) begin
            result_fifo_rdat <= fifo_mem[pop_cnt];
            pop_cnt          <= pop_cnt + 1;
        end
    end

    typedef struct packed {
        logic            last;
        logic [ID_W-1:0] id;
        logic [LANE_W-1:0] data;
    } res_t;

    res_t exp_q[$];

    logic [31:0] fixed_vals [0:7] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
    };

    int n_vec = 0;
    int n_err = 0;

    int  cyc = 0;
    int  rd_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_rd_cyc = -100;
    int  ready_duty = 100;
    bit  prev_valid = 1'b0;
    bit  prev_done = 1'b0;
    bit  hold_pending = 1'b0;
    res_t held;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Per-cycle observation at the falling edge.
    task automatic monitor();
        res_t got;
        res_t e;
        got.last = res_last;
        got.id   = res_id;
        got.data = res_data;

        if (result_fifo_empty || sys_rst)
            check_eq("rd_blocked", 64'(result_fifo_rd), 64'd0);
        if (result_fifo_rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        // A read word becomes visible two cycles after its rd (LOAD, then EMIT).
        if (res_valid && !prev_valid && !sys_rst)
            check_eq("load_latency", 64'(cyc - last_rd_cyc), 64'd2);

        if (res_valid) begin
            if (hold_pending)
                check_eq("stall_hold", 64'(got), 64'(held));
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("result_avail", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_data", 64'(res_data), 64'(e.data));
                    check_eq("res_id",   64'(res_id),   64'(e.id));
                    check_eq("res_last", 64'(res_last), 64'(e.last));
                end
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                held = got;
            end
        end else begin
            if (hold_pending && !sys_rst)
                check_eq("valid_dropped", 64'(res_valid), 64'd1);
            hold_pending = 1'b0;
        end

        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("busy_in_finish", 64'(busy), 64'd1);
        end
        if (prev_done)
            check_eq("busy_after_done", 64'(busy), 64'd0);

        prev_done  = done;
        prev_valid = res_valid;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge sys_clk);
        monitor();
        @(posedge sys_clk);
        #1;
        res_ready = ($urandom_range(0, 99) < ready_duty);
    endtask

    // Push the job's words into the FIFO and queue the expected results.
    task automatic load_job(input int n, input bit fixed);
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] sh;
        res_t e;
        int nw;
        nw = (n + LANES - 1) / LANES;
        for (int i = 0; i < nw; i++) begin
            for (int l = 0; l < LANES; l++) begin
                if (fixed && (i * LANES + l) < 8)
                    w[l*LANE_W +: LANE_W] = fixed_vals[i * LANES + l];
                else
                    w[l*LANE_W +: LANE_W] = $urandom;
            end
            words.push_back(w);
            fifo_mem[push_cnt] = w;
            push_cnt++;
        end
        for (int k = 0; k < n; k++) begin
            sh     = words[k / LANES] >> ((k % LANES) * LANE_W);
            e.data = sh[LANE_W-1:0];
            e.id   = ID_W'(k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_job(input int n, input int duty, input int empty_hold,
                           input bit poke, input bit fixed);
        int start_cyc;
        rd_cnt      = 0;
        done_cnt    = 0;
        ready_duty  = duty;
        force_empty = (empty_hold > 0);
        load_job(n, fixed);

        start     = 1'b1;
        num_pairs = ID_W'(n);
        start_cyc = cyc;
        cycle();
        start     = 1'b0;

        for (int i = 0; i < empty_hold; i++) cycle();
        if (empty_hold > 0) begin
            check_eq("rd_while_empty", 64'(rd_cnt), 64'd0);
            check_eq("busy_fetch_wait", 64'(busy), 64'd1);
            force_empty = 1'b0;
        end

        if (poke) begin
            cycle();
            start     = 1'b1;
            num_pairs = ID_W'(7);
            cycle();
            start     = 1'b0;
        end

        for (int i = 0; i < 3000 && done_cnt == 0; i++) cycle();
        check_eq("done_seen", 64'(done_cnt), 64'd1);
        cycle();
        cycle();
        check_eq("done_count", 64'(done_cnt), 64'd1);
        check_eq("busy_idle", 64'(busy), 64'd0);
        check_eq("rd_count", 64'(rd_cnt), 64'((n + LANES - 1) / LANES));
        check_eq("results_left", 64'(exp_q.size()), 64'd0);
        if (n == 0) begin
            // IDLE accepts start and enters FINISH on the same edge, so done
            // is seen in the cycle right after the start cycle.
            check_eq("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
        end
    endtask

    initial begin
        sys_rst     = 1'b1;
        start       = 1'b0;
        num_pairs   = '0;
        res_ready   = 1'b0;
        force_empty = 1'b0;
        ready_duty  = 100;
        repeat (3) cycle();
        sys_rst = 1'b0;
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_done",  64'(done), 64'd0);
        check_eq("rst_rd",    64'(result_fifo_rd), 64'd0);
        check_eq("rst_data",  64'({res_data, res_id, res_last}), 64'd0);
        cycle();

        run_job(8, 100, 0, 1'b0, 1'b1);   // two full words, fixed values
        run_job(5, 100, 0, 1'b0, 1'b0);   // padding lanes in the last word
        run_job(0, 100, 0, 1'b0, 1'b0);   // empty job
        run_job(12, 30, 0, 1'b0, 1'b0);   // heavy back-pressure
        run_job(4, 100, 20, 1'b0, 1'b0);  // FIFO empty while fetching

        // Reset in the middle of EMIT, at lane 2 of the first word.
        rd_cnt     = 0;
        done_cnt   = 0;
        ready_duty = 100;
        load_job(8, 1'b0);
        start     = 1'b1;
        num_pairs = ID_W'(8);
        cycle();
        start = 1'b0;
        for (int i = 0; i < 40 && !(res_valid && res_id == ID_W'(2)); i++) cycle();
        check_eq("reached_lane2", 64'({res_valid, res_id}), 64'({1'b1, 16'd2}));
        sys_rst    = 1'b1;
        ready_duty = 0;
        res_ready  = 1'b0;
        cycle();
        sys_rst = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        check_eq("midrst_valid", 64'(res_valid), 64'd0);
        check_eq("midrst_busy",  64'(busy), 64'd0);
        check_eq("midrst_done",  64'(done), 64'd0);
        check_eq("midrst_rd",    64'(result_fifo_rd), 64'd0);
        check_eq("midrst_data",  64'({res_data, res_id, res_last}), 64'd0);
        ready_duty = 100;
        cycle();
        run_job(4, 100, 0, 1'b1, 1'b0);   // clean restart, start poked while busy

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 13), $urandom_range(20, 100), 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
